// File: rtl/bz_tune_meter.sv
// Tone-period decoder: synchronizes and deglitches a square wave, then measures the
// rising-to-rising period and high time and flags lock and loss of signal.
module bz_tune_meter #(
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned FILT       = 4,
  parameter int unsigned MAX_PERIOD = 1000000,
  parameter int unsigned TOL        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] param_est,
  output logic             period_valid,
  output logic             locked,
  output logic             no_signal
);

  localparam int unsigned FW = (FILT < 2) ? 1 : $clog2(FILT + 1);
  localparam logic [FW-1:0]    FiltLast = FW'(FILT - 1);
  localparam logic [CNT_W-1:0] MaxCnt   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W:0]   TolW     = (CNT_W + 1)'(TOL);

  typedef enum logic {StWait, StMeasure} state_e;

  state_e          state;
  logic            tone_s1, tone_s2;
  logic            tone_f, tone_f_d1;
  logic [FW-1:0]   filt_cnt;
  logic [CNT_W-1:0] cnt, hcnt;
  logic            have_prev;

  logic             rise;
  logic [CNT_W:0]   diff;
  logic             within_tol;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] par_new;

  // Synchronizer and level filter run regardless of en so re-enable sees a settled level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_s1   <= 1'b0;
      tone_s2   <= 1'b0;
      tone_f    <= 1'b0;
      tone_f_d1 <= 1'b0;
      filt_cnt  <= '0;
    end else begin
      tone_s1   <= tone_in;
      tone_s2   <= tone_s1;
      tone_f_d1 <= tone_f;
      if (tone_s2 != tone_f) begin
        if (filt_cnt == FiltLast) begin
          tone_f   <= tone_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_comb begin
    rise       = tone_f & ~tone_f_d1;
    diff       = (cnt >= period) ? ({1'b0, cnt} - {1'b0, period})
                                 : ({1'b0, period} - {1'b0, cnt});
    within_tol = (diff <= TolW);
    half       = cnt >> 1;
    par_new    = (half == '0) ? '0 : half - CNT_W'(1);
  end

  // cnt counts cycles since the last accepted edge including the current one, so on
  // the next edge it equals the period directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StWait;
      cnt          <= '0;
      hcnt         <= '0;
      have_prev    <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      param_est    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!en) begin
        state     <= StWait;
        cnt       <= '0;
        hcnt      <= '0;
        have_prev <= 1'b0;
        locked    <= 1'b0;
      end else begin
        unique case (state)
          StWait: begin
            if (rise) begin
              state <= StMeasure;
              cnt   <= CNT_W'(1);
              hcnt  <= CNT_W'(1);
            end
          end
          StMeasure: begin
            // An edge on the timeout cycle takes priority over the timeout.
            if (rise) begin
              period       <= cnt;
              high_time    <= hcnt;
              param_est    <= par_new;
              period_valid <= 1'b1;
              locked       <= have_prev & within_tol;
              have_prev    <= 1'b1;
              no_signal    <= 1'b0;
              cnt          <= CNT_W'(1);
              hcnt         <= CNT_W'(1);
            end else if (cnt == MaxCnt) begin
              state     <= StWait;
              no_signal <= 1'b1;
              locked    <= 1'b0;
              have_prev <= 1'b0;
              cnt       <= '0;
              hcnt      <= '0;
            end else begin
              cnt  <= cnt + CNT_W'(1);
              hcnt <= hcnt + CNT_W'(tone_f);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bz_tune_meter.sv
// Self-checking bench for bz_tune_meter: square waves described as high/low run lengths,
// expectations derived from those run lengths.
module tb_bz_tune_meter;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned FILT  = 4;
  localparam int unsigned MAX_P = 5000;
  localparam int unsigned TOL   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             tone_in = 1'b0;
  logic [CNT_W-1:0] period, high_time, param_est;
  logic             period_valid, locked, no_signal;

  bz_tune_meter #(.CNT_W(CNT_W), .FILT(FILT), .MAX_PERIOD(MAX_P), .TOL(TOL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tone_in(tone_in), .period(period),
    .high_time(high_time), .param_est(param_est), .period_valid(period_valid),
    .locked(locked), .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int     per;
    int     hi;
    int     par;
    logic   lk;
    longint cyc;
  } obs_t;

  obs_t   obs_q[$];
  obs_t   obs;
  longint cyc = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (period_valid === 1'b1) begin
      obs.per = int'(period);
      obs.hi  = int'(high_time);
      obs.par = int'(param_est);
      obs.lk  = locked;
      obs.cyc = cyc;
      obs_q.push_back(obs);
    end
  end

  // Wave description and expected results.
  int   his[$], los[$];
  int   exp_per[$], exp_hi[$], exp_par[$];
  logic exp_lk[$];

  function automatic void build_exp();
    int p, prev;
    exp_per.delete(); exp_hi.delete(); exp_par.delete(); exp_lk.delete();
    prev = 0;
    foreach (his[i]) begin
      p = his[i] + los[i];
      exp_per.push_back(p);
      exp_hi.push_back(his[i]);
      exp_par.push_back((p / 2 > 0) ? p / 2 - 1 : 0);
      exp_lk.push_back(i > 0 && ((p > prev) ? p - prev : prev - p) <= int'(TOL));
      prev = p;
    end
  endfunction

  task automatic drive(input logic lvl, input int len, input int gl);
    tone_in = lvl;
    for (int i = 0; i < len; i++) begin
      if (gl > 0 && len >= 20 && i == len / 2) tone_in = ~lvl;
      if (gl > 0 && len >= 20 && i == len / 2 + gl) tone_in = lvl;
      @(negedge clk);
    end
  endtask

  // Leading low, the listed periods, then one closing rising edge.
  task automatic run_wave(input bit glitch);
    drive(1'b0, 30, 0);
    foreach (his[i]) begin
      drive(1'b1, his[i], glitch ? int'($urandom_range(3, 1)) : 0);
      drive(1'b0, los[i], glitch ? int'($urandom_range(3, 1)) : 0);
    end
    drive(1'b1, 20, 0);
    drive(1'b0, 20, 0);
  endtask

  task automatic idle();
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    obs_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (period !== '0 || high_time !== '0 || param_est !== '0 || period_valid !== 1'b0 ||
        locked !== 1'b0 || no_signal !== 1'b0) begin
      failures++;
      $display("FAIL reset: got per=%0d hi=%0d par=%0d pv=%b lk=%b ns=%b want all 0",
               period, high_time, param_est, period_valid, locked, no_signal);
    end
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) @(negedge clk);
    obs_q.delete();
  endtask

  task automatic test_steady();
    idle();
    his = '{500, 500, 500, 500};
    los = '{500, 500, 500, 500};
    run_wave(1'b0);
    build_exp();
    checks++;
    if (obs_q.size() !== his.size()) begin
      failures++;
      $display("FAIL steady_count: got %0d want %0d", obs_q.size(), his.size());
    end
    for (int i = 0; i < obs_q.size() && i < his.size(); i++) begin
      checks++;
      if (obs_q[i].per !== exp_per[i] || obs_q[i].hi !== exp_hi[i] ||
          obs_q[i].par !== exp_par[i] || obs_q[i].lk !== exp_lk[i]) begin
        failures++;
        $display("FAIL steady[%0d]: got per=%0d hi=%0d par=%0d lk=%b want %0d %0d %0d %b", i,
                 obs_q[i].per, obs_q[i].hi, obs_q[i].par, obs_q[i].lk,
                 exp_per[i], exp_hi[i], exp_par[i], exp_lk[i]);
      end
      if (i > 0) begin
        checks++;
        if (obs_q[i].cyc - obs_q[i-1].cyc !== longint'(exp_per[i])) begin
          failures++;
          $display("FAIL steady_spacing[%0d]: got %0d want %0d", i,
                   obs_q[i].cyc - obs_q[i-1].cyc, exp_per[i]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    idle();
    his = '{500, 500, 500, 500};
    los = '{500, 500, 500, 500};
    run_wave(1'b1);
    build_exp();
    checks++;
    if (obs_q.size() !== his.size()) begin
      failures++;
      $display("FAIL glitch_count: got %0d want %0d", obs_q.size(), his.size());
    end
    for (int i = 0; i < obs_q.size() && i < his.size(); i++) begin
      checks++;
      if (obs_q[i].per !== exp_per[i] || obs_q[i].hi !== exp_hi[i] ||
          obs_q[i].par !== exp_par[i] || obs_q[i].lk !== exp_lk[i]) begin
        failures++;
        $display("FAIL glitch[%0d]: got per=%0d hi=%0d par=%0d lk=%b want %0d %0d %0d %b", i,
                 obs_q[i].per, obs_q[i].hi, obs_q[i].par, obs_q[i].lk,
                 exp_per[i], exp_hi[i], exp_par[i], exp_lk[i]);
      end
    end
  endtask

  // Includes a step of exactly TOL (stays locked) and TOL+1 (drops lock).
  task automatic test_step();
    idle();
    his = '{500, 500, 600, 600, 600, 602, 604};
    los = '{500, 500, 600, 600, 600, 602, 605};
    run_wave(1'b0);
    build_exp();
    checks++;
    if (obs_q.size() !== his.size()) begin
      failures++;
      $display("FAIL step_count: got %0d want %0d", obs_q.size(), his.size());
    end
    for (int i = 0; i < obs_q.size() && i < his.size(); i++) begin
      checks++;
      if (obs_q[i].per !== exp_per[i] || obs_q[i].hi !== exp_hi[i] ||
          obs_q[i].par !== exp_par[i] || obs_q[i].lk !== exp_lk[i]) begin
        failures++;
        $display("FAIL step[%0d]: got per=%0d hi=%0d par=%0d lk=%b want %0d %0d %0d %b", i,
                 obs_q[i].per, obs_q[i].hi, obs_q[i].par, obs_q[i].lk,
                 exp_per[i], exp_hi[i], exp_par[i], exp_lk[i]);
      end
    end
  endtask

  // Period equal to the timeout: the edge must win.
  task automatic test_max_edge();
    idle();
    his = '{2500, 2500, 2500};
    los = '{2500, 2500, 2500};
    run_wave(1'b0);
    build_exp();
    checks++;
    if (obs_q.size() !== his.size()) begin
      failures++;
      $display("FAIL max_edge_count: got %0d want %0d", obs_q.size(), his.size());
    end
    for (int i = 0; i < obs_q.size() && i < his.size(); i++) begin
      checks++;
      if (obs_q[i].per !== exp_per[i] || obs_q[i].lk !== exp_lk[i]) begin
        failures++;
        $display("FAIL max_edge[%0d]: got per=%0d lk=%b want %0d %b", i,
                 obs_q[i].per, obs_q[i].lk, exp_per[i], exp_lk[i]);
      end
    end
    checks++;
    if (no_signal !== 1'b0) begin
      failures++;
      $display("FAIL max_edge_nosig: got %b want 0", no_signal);
    end
  endtask

  task automatic test_timeout();
    int n;
    idle();
    drive(1'b0, 30, 0);
    drive(1'b1, 500, 0);
    drive(1'b0, 500, 0);
    drive(1'b1, 500, 0);
    drive(1'b0, 500, 0);
    tone_in = 1'b1;
    n = 0;
    while (period_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (period_valid !== 1'b1 || locked !== 1'b1 || period !== 20'd1000) begin
      failures++;
      $display("FAIL timeout_prelock: got pv=%b lk=%b per=%0d want 1 1 1000",
               period_valid, locked, period);
    end
    n = 0;
    while (no_signal !== 1'b1 && n < 6000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== int'(MAX_P)) begin
      failures++;
      $display("FAIL timeout_delay: got %0d want %0d", n, MAX_P);
    end
    checks++;
    if (no_signal !== 1'b1 || locked !== 1'b0 || period !== 20'd1000 ||
        high_time !== 20'd500 || param_est !== 20'd499) begin
      failures++;
      $display("FAIL timeout_state: got ns=%b lk=%b per=%0d hi=%0d par=%0d want 1 0 1000 500 499",
               no_signal, locked, period, high_time, param_est);
    end
    @(negedge clk);
    obs_q.delete();
    drive(1'b0, 100, 0);
    drive(1'b1, 400, 0);
    drive(1'b0, 400, 0);
    checks++;
    if (no_signal !== 1'b1 || obs_q.size() !== 0) begin
      failures++;
      $display("FAIL resume_first_edge: got ns=%b pulses=%0d want 1 0", no_signal, obs_q.size());
    end
    drive(1'b1, 400, 0);
    drive(1'b0, 20, 0);
    checks++;
    if (obs_q.size() !== 1 || no_signal !== 1'b0 || period !== 20'd800 ||
        high_time !== 20'd400 || locked !== 1'b0) begin
      failures++;
      $display("FAIL resume_second_edge: got n=%0d ns=%b per=%0d hi=%0d lk=%b want 1 0 800 400 0",
               obs_q.size(), no_signal, period, high_time, locked);
    end
  endtask

  task automatic test_enable();
    idle();
    drive(1'b0, 30, 0);
    drive(1'b1, 500, 0);
    drive(1'b0, 500, 0);
    drive(1'b1, 500, 0);
    drive(1'b0, 250, 0);
    en = 1'b0;
    obs_q.delete();
    drive(1'b0, 250, 0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 500, 0);
      drive(1'b0, 500, 0);
    end
    drive(1'b1, 500, 0);
    drive(1'b0, 250, 0);
    checks++;
    if (obs_q.size() !== 0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL en_low: got pulses=%0d lk=%b want 0 0", obs_q.size(), locked);
    end
    en = 1'b1;
    his = '{500, 500, 500};
    los = '{500, 500, 500};
    run_wave(1'b0);
    build_exp();
    checks++;
    if (obs_q.size() !== his.size()) begin
      failures++;
      $display("FAIL en_count: got %0d want %0d", obs_q.size(), his.size());
    end
    for (int i = 0; i < obs_q.size() && i < his.size(); i++) begin
      checks++;
      if (obs_q[i].per !== exp_per[i] || obs_q[i].lk !== exp_lk[i]) begin
        failures++;
        $display("FAIL en_reenable[%0d]: got per=%0d lk=%b want %0d %b", i,
                 obs_q[i].per, obs_q[i].lk, exp_per[i], exp_lk[i]);
      end
    end
  endtask

  task automatic test_random();
    int p, prev, hi;
    idle();
    his.delete();
    los.delete();
    prev = int'($urandom_range(300, 40));
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(1, 0) == 1) p = prev + int'($urandom_range(12, 0)) - 6;
      else p = int'($urandom_range(300, 40));
      if (p < 40) p = 40;
      hi = int'($urandom_range(p - 12, 12));
      his.push_back(hi);
      los.push_back(p - hi);
      prev = p;
    end
    run_wave(1'b1);
    build_exp();
    checks++;
    if (obs_q.size() !== his.size()) begin
      failures++;
      $display("FAIL random_count: got %0d want %0d", obs_q.size(), his.size());
    end
    for (int i = 0; i < obs_q.size() && i < his.size(); i++) begin
      checks++;
      if (obs_q[i].per !== exp_per[i] || obs_q[i].hi !== exp_hi[i] ||
          obs_q[i].par !== exp_par[i] || obs_q[i].lk !== exp_lk[i]) begin
        failures++;
        $display("FAIL random[%0d]: got per=%0d hi=%0d par=%0d lk=%b want %0d %0d %0d %b", i,
                 obs_q[i].per, obs_q[i].hi, obs_q[i].par, obs_q[i].lk,
                 exp_per[i], exp_hi[i], exp_par[i], exp_lk[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    drive(1'b0, 30, 0);
    drive(1'b1, 300, 0);
    drive(1'b0, 300, 0);
    drive(1'b1, 300, 0);
    drive(1'b0, 150, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (period !== '0 || high_time !== '0 || param_est !== '0 || period_valid !== 1'b0 ||
        locked !== 1'b0 || no_signal !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got per=%0d hi=%0d par=%0d pv=%b lk=%b ns=%b want all 0",
               period, high_time, param_est, period_valid, locked, no_signal);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    his = '{600, 600};
    los = '{600, 600};
    run_wave(1'b0);
    build_exp();
    checks++;
    if (obs_q.size() !== his.size()) begin
      failures++;
      $display("FAIL reset_mid_count: got %0d want %0d", obs_q.size(), his.size());
    end
    for (int i = 0; i < obs_q.size() && i < his.size(); i++) begin
      checks++;
      if (obs_q[i].per !== exp_per[i] || obs_q[i].hi !== exp_hi[i] ||
          obs_q[i].lk !== exp_lk[i]) begin
        failures++;
        $display("FAIL reset_mid_post[%0d]: got per=%0d hi=%0d lk=%b want %0d %0d %b", i,
                 obs_q[i].per, obs_q[i].hi, obs_q[i].lk, exp_per[i], exp_hi[i], exp_lk[i]);
      end
    end
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_steady();
    test_glitch();
    test_step();
    test_max_edge();
    test_timeout();
    test_enable();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bz_tune_meter.md
# bz_tune_meter

Tone-period decoder for the buzzer path. Samples an incoming square wave (buzzer drive line loop-back or a comparator-conditioned sensor tone), deglitches it, and measures the clock count between rising edges and the high time. Reports the half-period generator setting that would reproduce the tone, and flags lock and loss of signal. Sits beside the buzzer tone generator for self-test and for tone-command detection.

## Interface

- CNT_W, 20, width of all count outputs
- FILT, 4, consecutive stable samples required to accept a level change (≥1)
- MAX_PERIOD, 1000000, cycles without a rising edge before declaring loss of signal (< 2^CNT_W)
- TOL, 4, maximum |period difference| between consecutive periods that keeps lock

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  measurement enable
- tone_in  in  1  asynchronous square-wave input
- period  out  CNT_W  last measured rising-to-rising period, in clk cycles
- high_time  out  CNT_W  cycles the filtered input was high within that period
- param_est  out  CNT_W  equivalent generator setting: (period>>1) − 1, saturating at 0
- period_valid  out  1  one-cycle pulse when period/high_time/param_est update
- locked  out  1  two or more consecutive periods within TOL
- no_signal  out  1  no rising edge for MAX_PERIOD cycles

## Operation

- Input path: 2-flop synchronizer, then filter. Filtered level tone_f adopts the synchronized value only after it differs from tone_f for FILT consecutive cycles; shorter pulses are discarded entirely.
- Rising edge = tone_f transitions 0→1 (registered compare).
- States: WAIT (no reference edge held), MEASURE (counting since last rising edge).
- WAIT: counter held at 0. On rising edge → MEASURE, counter starts; no period_valid.
- MEASURE: counter increments each cycle; high counter increments each cycle tone_f=1.
  - Rising edge: period ← cycles since previous rising edge; high_time ← high count; param_est updated; period_valid pulses; counters restart; stays MEASURE; no_signal ← 0.
  - Counter reaches MAX_PERIOD with no edge: no_signal ← 1, locked ← 0, → WAIT. period/high_time/param_est hold last values.
- Lock: on each period_valid, if a previous valid period exists since last WAIT and |new − previous| ≤ TOL, locked ← 1; otherwise locked ← 0. First period after WAIT always leaves locked at 0.
- Edge coinciding with timeout cycle: edge wins (period = MAX_PERIOD, no timeout).
- en=0: state → WAIT, counters cleared, locked ← 0, no pulses; period/high_time/param_est/no_signal hold. Synchronizer and filter keep running, so an input already high at re-enable does not produce an edge.
- Arithmetic unsigned CNT_W; difference computed CNT_W+1 bits, no wrap.

## Timing

- Reset values: period 0, high_time 0, param_est 0, period_valid 0, locked 0, no_signal 0; state WAIT; tone_f 0.
- Latency tone_in edge → tone_f change: 2 (sync) + FILT cycles. Rising edge → period_valid: one further cycle; outputs valid on the same cycle as the pulse.
- period_valid never high two consecutive cycles (min accepted period ≥ 2·FILT).
- locked and no_signal update in the same cycle as the event causing them.
- Reset mid-measurement: all state to reset values immediately; first period_valid after release needs two accepted rising edges.

## Test plan

- Square wave period 1000, high 500 → period=1000, high_time=500, param_est=499, period_valid every 1000 cycles; locked=1 after second pulse.
- Same wave with 3-cycle glitches (FILT=4) mid-high and mid-low → outputs unchanged, no extra period_valid.
- Period step 1000→1200, TOL=4 → locked drops on first 1200 measurement, reasserts on next; period=1200, param_est=599.
- MAX_PERIOD=5000, input stops → no_signal=1 and locked=0 exactly 5000 cycles after last accepted edge; resume → no_signal clears on second rising edge, period correct.
- en low for 3000 cycles mid-stream then high → no pulses while low; first period_valid only after two new rising edges; locked after third.
- rst_n asserted mid-period, asynchronously → all outputs 0 within same cycle; post-reset measurement matches input period.
